// File: rtl/bnn_pe_pkg.sv
// Shared definitions for the binary (XNOR/popcount) conv PEs.
//  - IN_SEL_*   : operand source select codes
//  - pe_state_t : accumulation FSM encoding
//  - clog2 / pc_width : elaboration-time width helpers
package bnn_pe_pkg;

    localparam logic [1:0] IN_SEL_BOTTOM = 2'd0;
    localparam logic [1:0] IN_SEL_SIDE   = 2'd1;
    localparam logic [1:0] IN_SEL_TOP    = 2'd2;
    localparam logic [1:0] IN_SEL_HOLD   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } pe_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Bits needed to hold a popcount of 'lanes' bits (0..lanes inclusive).
    function automatic int pc_width(input int lanes);
        return clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational XNOR + popcount: o_pc = number of positions where i_a and i_b agree.
// Ports:
//  i_a, i_b  in  LANES           binary vectors
//  o_pc      out pc_width(LANES) match count
// Lanes are zero-padded to a power of two and summed as a balanced binary tree
// stored heap-style (node n has children 2n+1, 2n+2).
module xnor_popcount
    import bnn_pe_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic [LANES-1:0]           i_a,
    input  logic [LANES-1:0]           i_b,
    output logic [pc_width(LANES)-1:0] o_pc
);

    localparam int PCW    = pc_width(LANES);
    localparam int LEAVES = 1 << clog2(LANES);

    logic [LEAVES-1:0] w_match;
    logic [PCW-1:0]    w_node [2*LEAVES-1];

    always_comb begin
        w_match              = '0;
        w_match[LANES-1:0]   = ~(i_a ^ i_b);
        for (int i = 0; i < LEAVES; i++)
            w_node[LEAVES-1+i] = PCW'(w_match[i]);
        // No node can exceed LANES, so PCW bits never overflow at any level.
        for (int n = LEAVES-2; n >= 0; n--)
            w_node[n] = w_node[2*n+1] + w_node[2*n+2];
    end

    assign o_pc = w_node[0];

endmodule

// File: rtl/xnor_conv_pe_vec.sv
// Vector XNOR conv PE: per beat, XNOR a LANES-wide activation against one resident
// weight vector, popcount, and accumulate a programmable number of beats on top of
// an incoming partial sum (saturating). Weights daisy-chain through registered outputs.
// Ports:
//  i_clk, i_rst (async, active-high), i_en (beat enable / stall)
//  i_weight_we/i_weight_addr/i_weight_in : bank write; o_weight_* : registered chain copy
//  i_kern_sel : bank entry for this beat; i_in_sel : operand source
//  i_in_top/i_in_bottom/i_in_side : activations; o_out_side : operand used (forwarded)
//  i_start, i_acc_len, i_pcountin : run control; o_pcountout, o_valid, o_busy, o_sat : result
module xnor_conv_pe_vec
    import bnn_pe_pkg::*;
#(
    parameter  int LANES       = 8,
    parameter  int NUM_KERNELS = 4,
    parameter  int PSUM_WIDTH  = 12,
    parameter  int LEN_WIDTH   = 8,
    localparam int KW          = (NUM_KERNELS > 1) ? clog2(NUM_KERNELS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_weight_we,
    input  logic [KW-1:0]         i_weight_addr,
    input  logic [LANES-1:0]      i_weight_in,
    output logic                  o_weight_we_out,
    output logic [KW-1:0]         o_weight_addr_out,
    output logic [LANES-1:0]      o_weight_out,
    input  logic [KW-1:0]         i_kern_sel,
    input  logic [1:0]            i_in_sel,
    input  logic [LANES-1:0]      i_in_top,
    input  logic [LANES-1:0]      i_in_bottom,
    input  logic [LANES-1:0]      i_in_side,
    output logic [LANES-1:0]      o_out_side,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_acc_len,
    input  logic [PSUM_WIDTH-1:0] i_pcountin,
    output logic [PSUM_WIDTH-1:0] o_pcountout,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_sat
);

    localparam int PCW = pc_width(LANES);

    if (PSUM_WIDTH < PCW) begin : g_width_chk
        $error("PSUM_WIDTH too small to hold one beat's popcount");
    end

    pe_state_t             r_state, w_state_nxt;
    logic [LANES-1:0]      r_bank [NUM_KERNELS];
    logic [LANES-1:0]      r_top, r_op;
    logic [PSUM_WIDTH-1:0] r_acc, r_pcountout;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic                  r_sat;

    logic [LANES-1:0]      w_x, w_wsel;
    logic [PCW-1:0]        w_pc;
    logic [PSUM_WIDTH-1:0] w_base, w_sum;
    logic [PSUM_WIDTH:0]   w_raw;
    logic                  w_clamp, w_load, w_beat, w_fin, w_short;
    logic [LEN_WIDTH-1:0]  w_len_m1;

    // Operand select; HOLD reuses the operand registered on the last enabled beat.
    always_comb begin
        w_x = r_op;
        case (i_in_sel)
            IN_SEL_BOTTOM: w_x = i_in_bottom;
            IN_SEL_SIDE:   w_x = i_in_side;
            IN_SEL_TOP:    w_x = r_top;
            default:       w_x = r_op;
        endcase
    end

    // Bank read comes from the register, so a same-cycle write is not visible yet.
    assign w_wsel = (int'(i_kern_sel) < NUM_KERNELS) ? r_bank[i_kern_sel] : '0;

    xnor_popcount #(.LANES(LANES)) u_pc (
        .i_a  (w_x),
        .i_b  (w_wsel),
        .o_pc (w_pc)
    );

    // Saturating add at one extra bit; the carry-out is exactly the clamp condition.
    assign w_base  = (r_state == ST_ACC) ? r_acc : i_pcountin;
    assign w_raw   = {1'b0, w_base} + (PSUM_WIDTH+1)'(w_pc);
    assign w_clamp = w_raw[PSUM_WIDTH];
    assign w_sum   = w_clamp ? '1 : w_raw[PSUM_WIDTH-1:0];

    assign w_short  = (i_acc_len <= LEN_WIDTH'(1));
    assign w_len_m1 = w_short ? '0 : i_acc_len - LEN_WIDTH'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_beat      = 1'b0;
        w_fin       = 1'b0;
        case (r_state)
            ST_IDLE: if (i_en && i_start) begin
                w_load      = 1'b1;
                w_fin       = w_short;
                w_state_nxt = w_short ? ST_DONE : ST_ACC;
            end
            ST_ACC: if (i_en) begin
                w_beat = 1'b1;
                if (r_cnt == LEN_WIDTH'(1)) begin
                    w_fin       = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Back-to-back start is accepted here; otherwise leave regardless of en.
                w_state_nxt = ST_IDLE;
                if (i_en && i_start) begin
                    w_load      = 1'b1;
                    w_fin       = w_short;
                    w_state_nxt = w_short ? ST_DONE : ST_ACC;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_pcountout <= '0;
            r_top       <= '0;
            r_op        <= '0;
        end else begin
            if (i_en) begin
                r_top <= i_in_top;
                r_op  <= w_x;
            end
            if (w_load) begin
                r_acc <= w_sum;
                r_sat <= w_clamp;
                r_cnt <= w_len_m1;
            end else if (w_beat) begin
                r_acc <= w_sum;
                r_sat <= r_sat | w_clamp;
                r_cnt <= r_cnt - LEN_WIDTH'(1);
            end
            if (w_fin) r_pcountout <= w_sum;
        end
    end

    // Weight bank and chain registers run every cycle, independent of i_en.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_KERNELS; k++) r_bank[k] <= '0;
            o_weight_we_out   <= 1'b0;
            o_weight_addr_out <= '0;
            o_weight_out      <= '0;
        end else begin
            if (i_weight_we && (int'(i_weight_addr) < NUM_KERNELS))
                r_bank[i_weight_addr] <= i_weight_in;
            o_weight_we_out   <= i_weight_we;
            o_weight_addr_out <= i_weight_addr;
            o_weight_out      <= i_weight_in;
        end
    end

    assign o_out_side  = r_op;
    assign o_pcountout = r_pcountout;
    assign o_valid     = (r_state == ST_DONE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_sat       = r_sat;

endmodule

// File: tb/tb_xnor_conv_pe_vec.sv
module tb_xnor_conv_pe_vec;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, weight_we, start;
    logic [1:0]  weight_addr, kern_sel, in_sel;
    logic [7:0]  weight_in, in_top, in_bottom, in_side, acc_len;
    logic [11:0] pcountin;
    logic [5:0]  pcountin6;

    logic        o_wwe, o_valid, o_busy, o_sat;
    logic [1:0]  o_waddr;
    logic [7:0]  o_wout, o_side;
    logic [11:0] o_pout;

    logic        o6_wwe, o6_valid, o6_busy, o6_sat;
    logic [1:0]  o6_waddr;
    logic [7:0]  o6_wout, o6_side;
    logic [5:0]  o6_pout;

    always #5 clk = ~clk;

    xnor_conv_pe_vec #(.LANES(8), .NUM_KERNELS(4), .PSUM_WIDTH(12), .LEN_WIDTH(8)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .i_weight_we(weight_we), .i_weight_addr(weight_addr), .i_weight_in(weight_in),
        .o_weight_we_out(o_wwe), .o_weight_addr_out(o_waddr), .o_weight_out(o_wout),
        .i_kern_sel(kern_sel), .i_in_sel(in_sel),
        .i_in_top(in_top), .i_in_bottom(in_bottom), .i_in_side(in_side), .o_out_side(o_side),
        .i_start(start), .i_acc_len(acc_len), .i_pcountin(pcountin),
        .o_pcountout(o_pout), .o_valid(o_valid), .o_busy(o_busy), .o_sat(o_sat)
    );

    xnor_conv_pe_vec #(.LANES(8), .NUM_KERNELS(4), .PSUM_WIDTH(6), .LEN_WIDTH(8)) u_dut6 (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .i_weight_we(weight_we), .i_weight_addr(weight_addr), .i_weight_in(weight_in),
        .o_weight_we_out(o6_wwe), .o_weight_addr_out(o6_waddr), .o_weight_out(o6_wout),
        .i_kern_sel(kern_sel), .i_in_sel(in_sel),
        .i_in_top(in_top), .i_in_bottom(in_bottom), .i_in_side(in_side), .o_out_side(o6_side),
        .i_start(start), .i_acc_len(acc_len), .i_pcountin(pcountin6),
        .o_pcountout(o6_pout), .o_valid(o6_valid), .o_busy(o6_busy), .o_sat(o6_sat)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: bank contents, last in_top and last operand seen on an enabled beat.
    logic [7:0] m_bank [4];
    logic [7:0] m_top, m_op, m_wout;
    int         m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compute this cycle's reference popcount from the current inputs, update the
    // reference state the way the rules say the clock edge will, then clock.
    task automatic tick();
        logic [7:0] x;
        case (in_sel)
            2'd0:    x = in_bottom;
            2'd1:    x = in_side;
            2'd2:    x = m_top;
            default: x = m_op;
        endcase
        m_pc = $countones(~(x ^ m_bank[kern_sel]));
        if (en) begin
            m_top = in_top;
            m_op  = x;
        end
        if (weight_we) m_bank[weight_addr] = weight_in;
        m_wout = weight_in;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_bank[k] = '0;
        m_top = '0; m_op = '0; m_wout = '0; m_pc = 0;
    endtask

    task automatic rand_data();
        in_top    = 8'($urandom);
        in_bottom = 8'($urandom);
        in_side   = 8'($urandom);
        in_sel    = 2'($urandom_range(0, 3));
        kern_sel  = 2'($urandom_range(0, 3));
        weight_we = 1'($urandom_range(0, 1));
        weight_addr = 2'($urandom_range(0, 3));
        weight_in = 8'($urandom);
    endtask

    initial begin
        int len, beats, pin, expv, esat, ns;
        rst = 1'b1; en = 0; weight_we = 0; start = 0; weight_addr = 0; kern_sel = 0;
        in_sel = 0; weight_in = 0; in_top = 0; in_bottom = 0; in_side = 0;
        acc_len = 0; pcountin = 0; pcountin6 = 0;
        model_reset();
        #12;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_busy",  32'(o_busy), 0);
        chk("rst_sat",   32'(o_sat), 0);
        chk("rst_pout",  32'(o_pout), 0);
        chk("rst_side",  32'(o_side), 0);
        chk("rst_wout",  32'(o_wout), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Single-beat run: bank[2]=F0 against F0 -> 8 matches on top of 3.
        weight_we = 1; weight_addr = 2; weight_in = 8'hF0;
        tick();
        chk("chain_wout", 32'(o_wout), 32'hF0);
        chk("chain_we",   32'(o_wwe), 1);
        chk("chain_addr", 32'(o_waddr), 2);
        weight_we = 0;
        en = 1; start = 1; kern_sel = 2; in_sel = 0; in_bottom = 8'hF0; pcountin = 3; acc_len = 1;
        tick();
        chk("t2_valid", 32'(o_valid), 1);
        chk("t2_pout",  32'(o_pout), 11);
        chk("t2_busy",  32'(o_busy), 1);
        chk("t2_side",  32'(o_side), 32'hF0);
        en = 0; start = 0;
        tick();
        chk("t2_valid_drop", 32'(o_valid), 0);
        chk("t2_busy_drop",  32'(o_busy), 0);
        chk("t2_pout_hold",  32'(o_pout), 11);

        // Three beats with two-cycle stalls between: 8 + 7 + 4 = 19.
        en = 1; start = 1; acc_len = 3; pcountin = 0; in_bottom = 8'hF0;
        tick();
        chk("t3_b1_valid", 32'(o_valid), 0);
        start = 0; en = 0; in_bottom = 8'hAA;
        for (int s = 0; s < 2; s++) begin
            tick();
            chk("t3_stall_valid", 32'(o_valid), 0);
            chk("t3_stall_busy",  32'(o_busy), 1);
        end
        en = 1; in_bottom = 8'hF1;
        tick();
        chk("t3_b2_valid", 32'(o_valid), 0);
        en = 0; in_bottom = 8'h55;
        tick(); tick();
        chk("t3_stall2_valid", 32'(o_valid), 0);
        en = 1; in_bottom = 8'h00;
        tick();
        chk("t3_valid", 32'(o_valid), 1);
        chk("t3_pout",  32'(o_pout), 19);
        en = 0;
        tick();
        chk("t3_one_pulse", 32'(o_valid), 0);

        // in_sel=2 uses in_top captured on the previous enabled beat.
        en = 1; start = 1; acc_len = 2; pcountin = 0; in_sel = 0; in_bottom = 8'hF0; in_top = 8'hF0;
        tick();
        start = 0; in_sel = 2; in_top = 8'h00; in_bottom = 8'h00;
        tick();
        chk("t4_pout", 32'(o_pout), 16);
        chk("t4_side", 32'(o_side), 32'hF0);
        en = 0; in_sel = 0;
        tick();

        // Saturation on the 6-bit instance: 60 + 8 + 8 clamps at 63.
        en = 1; start = 1; acc_len = 2; pcountin6 = 60; pcountin = 0; kern_sel = 2; in_bottom = 8'hF0;
        tick();
        chk("t5_sat_early", 32'(o6_sat), 1);
        start = 0;
        tick();
        chk("t5_valid", 32'(o6_valid), 1);
        chk("t5_pout",  32'(o6_pout), 63);
        chk("t5_sat",   32'(o6_sat), 1);
        en = 0;
        tick();
        chk("t5_sat_sticky", 32'(o6_sat), 1);
        en = 1; start = 1; acc_len = 1; pcountin6 = 0;
        tick();
        chk("t5_sat_clear", 32'(o6_sat), 0);
        chk("t5_pout2",     32'(o6_pout), 8);
        en = 0; start = 0;
        tick();

        // Back-to-back start from DONE, with a same-cycle write to the selected entry.
        weight_we = 1; weight_addr = 1; weight_in = 8'h0F;
        tick();
        weight_we = 0;
        en = 1; start = 1; acc_len = 1; pcountin = 5; kern_sel = 2; in_bottom = 8'hF0;
        tick();
        chk("t6_valid_first", 32'(o_valid), 1);
        chk("t6_pout_first",  32'(o_pout), 13);
        start = 1; acc_len = 2; pcountin = 1; kern_sel = 1; in_bottom = 8'h0F;
        weight_we = 1; weight_addr = 1; weight_in = 8'hF0;
        tick();
        chk("t6_b2b_busy",  32'(o_busy), 1);
        chk("t6_b2b_valid", 32'(o_valid), 0);
        start = 0; weight_we = 0;
        tick();
        chk("t6_valid", 32'(o_valid), 1);
        chk("t6_pout",  32'(o_pout), 9);
        en = 0;
        tick();

        // Randomised runs against the reference model.
        for (int r = 0; r < 24; r++) begin
            len   = $urandom_range(0, 5);
            beats = (len == 0) ? 1 : len;
            pin   = (r % 3 == 0) ? 4095 - $urandom_range(0, 20) : $urandom_range(0, 4095);
            expv  = pin;
            esat  = 0;
            for (int b = 0; b < beats; b++) begin
                if (b > 0) begin
                    ns = $urandom_range(0, 2);
                    for (int s = 0; s < ns; s++) begin
                        rand_data();
                        en = 0; start = 1'($urandom_range(0, 1));
                        tick();
                        chk("rnd_stall_valid", 32'(o_valid), 0);
                    end
                end
                rand_data();
                en = 1;
                start = (b == 0);
                acc_len = (b == 0) ? 8'(len) : 8'($urandom);
                pcountin = (b == 0) ? 12'(pin) : 12'($urandom);
                tick();
                expv = expv + m_pc;
                if (expv > 4095) begin expv = 4095; esat = 1; end
                chk("rnd_side", 32'(o_side), 32'(m_op));
                if (b < beats - 1) chk("rnd_early_valid", 32'(o_valid), 0);
            end
            chk("rnd_valid", 32'(o_valid), 1);
            chk("rnd_pout",  32'(o_pout), 32'(expv));
            chk("rnd_sat",   32'(o_sat), 32'(esat));
            chk("rnd_wout",  32'(o_wout), 32'(m_wout));
            en = 0; start = 0; weight_we = 0;
            tick();
            chk("rnd_idle_valid", 32'(o_valid), 0);
            chk("rnd_idle_busy",  32'(o_busy), 0);
        end

        // Reset asserted between edges in the middle of an accumulation.
        en = 1; start = 1; acc_len = 5; pcountin = 2; in_sel = 0; in_bottom = 8'h3C; weight_we = 0;
        tick();
        start = 0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t1_valid", 32'(o_valid), 0);
        chk("t1_busy",  32'(o_busy), 0);
        chk("t1_pout",  32'(o_pout), 0);
        chk("t1_side",  32'(o_side), 0);
        model_reset();
        #1 rst = 1'b0;
        en = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t1_no_valid", 32'(o_valid), 0);
        end
        // Bank was cleared: 00 against zero weights is a full match.
        en = 1; start = 1; acc_len = 1; pcountin = 0; kern_sel = 2; in_sel = 0; in_bottom = 8'h00;
        tick();
        chk("t1_bank_zero", 32'(o_pout), 8);
        en = 0; start = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
